// File: rtl/add_sub_arbiter.sv
// Round-robin arbiter sharing one registered add/sub ALU among NREQ requesters.
// Issued operations return one cycle later and are tagged with the requester
// ID into a 2-entry response FIFO; issue is throttled so a returning result
// always has a free FIFO slot.
module add_sub_arbiter #(
  parameter int DWIDTH = 32,
  parameter int NREQ   = 4,
  parameter int IDW    = 2
) (
  input  logic                   clk,
  input  logic                   Resetn,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DWIDTH-1:0] req_a,
  input  logic [NREQ*DWIDTH-1:0] req_b,
  input  logic [NREQ-1:0]        req_sub,
  output logic [DWIDTH-1:0]      alu_a,
  output logic [DWIDTH-1:0]      alu_b,
  output logic                   alu_sub,
  input  logic [DWIDTH-1:0]      alu_p,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [DWIDTH-1:0]      rsp_data
);

  // Arbitration and in-flight tracking state
  logic [IDW-1:0]    r_rr_ptr;
  logic              r_inflight;
  logic [IDW-1:0]    r_inflight_id;

  // Response FIFO state
  logic [IDW-1:0]    r_mem_id   [2];
  logic [DWIDTH-1:0] r_mem_data [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_occ;

  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_pending;
  logic              w_can_issue;
  logic              w_found;
  logic [IDW-1:0]    w_cand;
  logic [IDW-1:0]    w_grant;
  logic              w_issue;
  logic [IDW-1:0]    w_rr_next;

  assign rsp_valid = (r_occ != 2'd0);
  assign w_pop     = rsp_valid & rsp_ready;
  assign w_push    = r_inflight;

  // Results already owed to the FIFO after this cycle's pop; one more issue is
  // safe only if at most one slot is spoken for. Gating with Resetn keeps
  // req_ready low while reset is asserted even if requesters stay valid.
  assign w_pending   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_can_issue = (w_pending <= 3'd1) & Resetn;

  // Round-robin search starting at r_rr_ptr for the first valid requester
  // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  assign w_issue   = w_found & w_can_issue;
  assign req_ready = w_issue ? ({{(NREQ-1){1'b0}}, 1'b1} << w_grant) : '0;
  assign w_rr_next = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + IDW'(1);

  // Steer the granted operands to the shared ALU; idle ALU inputs are zero
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sub = 1'b0;
    if (w_issue) begin
      alu_a   = req_a[w_grant*DWIDTH +: DWIDTH];
      alu_b   = req_b[w_grant*DWIDTH +: DWIDTH];
      alu_sub = req_sub[w_grant];
    end
  end

  // Control state: round-robin pointer, in-flight tag, FIFO pointers/occupancy
  // NOTE: sequential state uses non-blocking '<=' so every register sees pre-edge values.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_rr_ptr      <= '0;
      r_inflight    <= 1'b0;
      r_inflight_id <= '0;
      r_rd_ptr      <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_occ         <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_id <= w_grant;
        r_rr_ptr      <= w_rr_next;
      end
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // FIFO storage: capture the returning ALU result with its requester tag
  // NOTE: storage is not reset; occupancy gates visibility, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_id[r_wr_ptr]   <= r_inflight_id;
      r_mem_data[r_wr_ptr] <= alu_p;
    end
  end

  assign rsp_id   = rsp_valid ? r_mem_id[r_rd_ptr]   : '0;
  assign rsp_data = rsp_valid ? r_mem_data[r_rd_ptr] : '0;

  // A push into a full FIFO without a simultaneous pop would drop a result
  a_no_overflow: assert property (@(posedge clk) disable iff (!Resetn)
    !(r_inflight && (r_occ == 2'd2) && !w_pop));

endmodule

// File: doc/add_sub_arbiter.md
Name: add_sub_arbiter

Overview:
Round-robin arbiter that shares one registered adder/subtractor (1-cycle latency, p updated every clock) among NREQ requesting PEs in the SCGRA tile. Accepts operand pairs over valid/ready handshakes, drives the shared ALU, tracks the in-flight operation and tags each result with its requester ID. Results are buffered in a 2-entry response FIFO with backpressure, so no ALU result is ever lost.

Parameters:
DWIDTH, 32, operand/result width
NREQ, 4, number of requesters
IDW, 2, requester ID width (clog2(NREQ))

Ports:
clk  in  1  clock, all state on rising edge
Resetn  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operation valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_a  in  NREQ*DWIDTH  packed operand a; requester i at [i*DWIDTH +: DWIDTH]
req_b  in  NREQ*DWIDTH  packed operand b, same packing
req_sub  in  NREQ  1 = a-b, 0 = a+b
alu_a  out  DWIDTH  to shared ALU a
alu_b  out  DWIDTH  to shared ALU b
alu_sub  out  1  to shared ALU subtract
alu_p  in  DWIDTH  shared ALU result, valid the cycle after issue
rsp_valid  out  1  response FIFO non-empty
rsp_ready  in  1  consumer accepts head
rsp_id  out  IDW  requester ID of head result
rsp_data  out  DWIDTH  head result

Behaviour:
- Reset (async, Resetn=0): rr_ptr=0, inflight=0, FIFO empty (occ=0, rd/wr ptr=0). Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, alu_a=0, alu_b=0, alu_sub=0. Reset mid-operation discards in-flight and buffered results; first post-reset alu_p is ignored (inflight=0).
- pop = rsp_valid & rsp_ready.
- can_issue = (occ + inflight - pop) <= 1. Guarantees FIFO space when the issued result returns.
- Arbitration (combinational): if can_issue, grant the first i with req_valid[i]=1 searching rr_ptr, rr_ptr+1, ... mod NREQ. req_ready[grant]=1, others 0. No grant when can_issue=0 or no valid.
- Issue: handshake when req_valid[g] & req_ready[g]. Same cycle: alu_a/alu_b/alu_sub = granted operands (combinational mux); otherwise all zero. On the edge: inflight<=1, inflight_id<=g, rr_ptr<=(g+1) mod NREQ. No issue: inflight<=0, rr_ptr unchanged.
- Return: when inflight=1, alu_p is the issued result; push {inflight_id, alu_p} into FIFO at wr_ptr on that edge.
- FIFO: 2 entries; rsp_id/rsp_data = head entry (0 when empty). Simultaneous push and pop allowed at any occupancy incl. full (occ unchanged). Push never occurs when full without pop (guaranteed by can_issue); assertion flags violation. Pointers wrap 1->0.
- Throughput: 1 op/cycle sustained when rsp_ready=1; latency issue -> rsp_valid = 2 cycles (issue edge, push edge).
- Arithmetic: two's complement, modulo 2^DWIDTH, no overflow flag; wrap performed by ALU, passed unchanged.
- Request held with req_valid=1 and not granted must keep operands stable (protocol rule on requester); arbiter is not required to latch.
- Fairness: any continuously valid requester granted within NREQ issue slots.

Test Plan:
- Reset: Resetn=0 asynchronously mid-stream with occ=2 -> all outputs 0 immediately, after release first rsp only from post-reset requests.
- Single op: req 2 a=5 b=7 sub=0, rsp_ready=1 -> req_ready=4'b0100 cycle 0, rsp_valid with id=2 data=12 at cycle 2, one cycle only.
- Subtract/wrap: req 0 a=0 b=1 sub=1 -> data=32'hFFFFFFFF; a=32'h7FFFFFFF b=1 sub=0 -> data=32'h80000000.
- Round-robin: all 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,1,... one per cycle, responses ids in same order, 2-cycle latency.
- Backpressure: all valid, rsp_ready=0 -> exactly 2 issues then req_ready=0; occ=2, inflight=0; raise rsp_ready -> results drain in order, no loss/duplication, issue resumes same cycle as first pop.
- Simultaneous push/pop at occ=2 with rsp_ready toggling randomly for 1000 ops -> scoreboard matches every (id, a±b) in issue order.
